regfile_decode: RTL and testbench
=================================

# regfile_decode

Parametrised register file built around a generalised N-to-2^N one-hot write decoder: the successor to the fixed 5-to-32 decoder, which now owns the storage it selects. It sits in the CPU datapath between writeback and operand fetch. It has one write port, two asynchronous read ports, an optional write-to-read bypass and a per-register "written" bitmap for debug and test.

## Interface
Parameters:
- `DATA_W`, 32, register width in bits.
- `ADDR_W`, 5, address width; number of registers `NREG = 2**ADDR_W`.
- `ZERO_REG`, 1, when 1 register 0 is hard-wired to zero and ignores writes.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `we`  in  1  write enable.
- `waddr`  in  ADDR_W  write address.
- `wdata`  in  DATA_W  write data.
- `raddr1`, `raddr2`  in  ADDR_W  read addresses.
- `rdata1`, `rdata2`  out  DATA_W  read data, combinational from the addresses and the array.
- `wsel`  out  NREG  one-hot decode of `waddr` gated by `we`. It is all zeros when `we`=0 and combinational.
- `written`  out  NREG  bit i is set once register i has accepted a write since reset.
- `wr_count`  out  ADDR_W+1  number of distinct registers written since reset. It saturates at NREG.

## Operation
- Decode: `wsel[i] = we && (waddr == i)` for every i in 0..NREG-1. At most one bit is set. When `ZERO_REG`=1, `wsel[0]` is still reported, but register 0 is not updated.
- Write: on the rising edge with `resetn`=1, the register i with `wsel[i]`=1 is loaded with `wdata`, except register 0 when `ZERO_REG`=1.
- Read: `rdata1 = reg[raddr1]` and `rdata2 = reg[raddr2]`. They are forced to 0 when the address is 0 and `ZERO_REG`=1.
- Written bitmap: `written[i]` is set on an effective write to register i and is sticky until reset. Writes to register 0 with `ZERO_REG`=1 are not effective and do not set the bit.
- `wr_count` increments by 1 on an effective write to a register whose `written` bit was 0. Rewriting a register does not change the count.
- Reset: when `resetn`=0 at an edge, all registers, `written` and `wr_count` clear to 0. Reset overrides a simultaneous write.

## Timing
- Reset values: all registers are 0, `written`=0, `wr_count`=0, `rdata1`/`rdata2`=0 for any address, and `wsel` follows the inputs.
- Write latency is 1 cycle. Data presented at edge k is visible on `rdata*` immediately after edge k.
- Same-cycle read of the address being written, without bypass, returns the old value until the edge.
- Both read ports may address the same register, or the write address, in the same cycle. No conflict is possible and both ports return identical data.
- Reset asserted mid-sequence clears everything at that edge. The first write is accepted at the first edge after `resetn` returns to 1.
- `wr_count` reaches NREG−ZERO_REG at most. Further writes leave it unchanged, with no wrap-around.

## Configuration
- `REGFILE_BYPASS_EN` defined: when `we`=1, `raddrN == waddr`, and the target is not a hard-wired register 0, then `rdataN = wdata` in the same cycle, combinationally. This gives write-before-read semantics for the pipeline writeback stage.
- Not defined: reads always return the stored value, which is the old value during a same-cycle write. There is no combinational path from `wdata` to `rdata*`.

## Test plan
- Reset, then read all addresses -> `rdata1`=`rdata2`=0, `written`=0, `wr_count`=0.
- Sweep `we`=1 with `waddr`=0..31 and `wdata`=`32'hA5A5_0000+addr`, then read back each address -> every register returns its pattern and register 0 reads 0 (`ZERO_REG`=1). `wsel` equals `1<<waddr` on every cycle. The final `wr_count`=31.
- Write `32'hDEAD_BEEF` to register 7 with `raddr1`=7 in the same cycle -> with bypass `rdata1`=`32'hDEAD_BEEF` before the edge. Without bypass `rdata1` holds the old value before the edge and `32'hDEAD_BEEF` after it.
- Write register 3 twice (`32'h1`, then `32'h2`) -> `rdata`=`32'h2`, `written[3]`=1, `wr_count` incremented only once.
- Assert `resetn`=0 in the same cycle as a write of `32'hFFFF_FFFF` to register 5 -> register 5 reads 0 and `written[5]`=0 after that edge.
- Hold `we`=0 while toggling `waddr` and `wdata` -> `wsel`=0 and no register changes.

Source files
------------

// File: rtl/regfile_decode.sv
// -----------------------------------------------------------------------------
// regfile_decode
//   Register file with a generalised ADDR_W-to-2**ADDR_W one-hot write decoder.
//   It sits between writeback and operand fetch.
//   It provides one write port, two asynchronous read ports, a sticky per-register
//   "written" bitmap and a saturating count of distinct registers written.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   When defined, a read of the address being written in the same cycle returns
//   wdata combinationally (write-before-read).
//   When undefined, reads return the stored value, so there is no wdata->rdata path.
//
// Ports
//   clk       in   1         clock, all state updates on the rising edge
//   resetn    in   1         synchronous active-low reset
//   we        in   1         write enable
//   waddr     in   ADDR_W    write address
//   wdata     in   DATA_W    write data
//   raddr1/2  in   ADDR_W    read addresses
//   rdata1/2  out  DATA_W    combinational read data
//   wsel      out  NREG      one-hot decode of waddr gated by we
//   written   out  NREG      bit i set once register i accepted a write
//   wr_count  out  ADDR_W+1  number of distinct registers written, saturating
// -----------------------------------------------------------------------------
module regfile_decode #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [ADDR_W-1:0]      raddr1,
  input  logic [ADDR_W-1:0]      raddr2,
  output logic [DATA_W-1:0]      rdata1,
  output logic [DATA_W-1:0]      rdata2,
  output logic [(2**ADDR_W)-1:0] wsel,
  output logic [(2**ADDR_W)-1:0] written,
  output logic [ADDR_W:0]        wr_count
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(NREG);

  logic [DATA_W-1:0] r_mem [NREG];
  logic [NREG-1:0]   r_written;
  logic [ADDR_W:0]   r_wr_count;

  logic [NREG-1:0]   w_wsel;
  logic [NREG-1:0]   w_wen;
  logic              w_new_reg;

  // Decode stage.
  // wsel reports every decoded write, including register 0.
  // w_wen holds only the writes that actually update storage.
  always_comb begin
    w_wsel = '0;
    for (int i = 0; i < NREG; i++) begin
      w_wsel[i] = we && (waddr == ADDR_W'(i));
    end
    w_wen = w_wsel;
    if (ZERO_REG != 0) begin
      w_wen[0] = 1'b0;
    end
  end

  // An effective write to a register not yet marked bumps the count.
  assign w_new_reg = |(w_wen & ~r_written);

  // Storage / bookkeeping stage.
  // Reset clears everything and wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
      r_written  <= '0;
      r_wr_count <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_wen[i]) begin
          r_mem[i] <= wdata;
        end
      end
      r_written <= r_written | w_wen;
      // The guard prevents wrap-around, even though NREG-ZERO_REG is never exceeded.
      if (w_new_reg && (r_wr_count != CNT_MAX)) begin
        r_wr_count <= r_wr_count + 1'b1;
      end
    end
  end

  // Read stage.
  // Zero forcing comes last, so a hard-wired register 0 is never bypassed.
  always_comb begin
    rdata1 = r_mem[raddr1];
`ifdef REGFILE_BYPASS_EN
    if (we && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end
`endif
    if ((ZERO_REG != 0) && (raddr1 == '0)) begin
      rdata1 = '0;
    end
  end

  always_comb begin
    rdata2 = r_mem[raddr2];
`ifdef REGFILE_BYPASS_EN
    if (we && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end
`endif
    if ((ZERO_REG != 0) && (raddr2 == '0)) begin
      rdata2 = '0;
    end
  end

  assign wsel     = w_wsel;
  assign written  = r_written;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_regfile_decode.sv
// -----------------------------------------------------------------------------
// tb_regfile_decode
//   Self-checking bench for regfile_decode with default parameters
//   (DATA_W=32, ADDR_W=5, ZERO_REG=1).
//   Expected values are pushed onto a scoreboard queue as stimulus is driven.
//   They are popped and compared against the DUT outputs.
//   Inputs change on the falling edge, and outputs are sampled 1 time unit later
//   or 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_regfile_decode;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  logic              clk = 1'b0;
  logic              resetn;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [NREG-1:0]   wsel;
  logic [NREG-1:0]   written;
  logic [ADDR_W:0]   wr_count;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q [$];
  logic [31:0] model [NREG];
  logic [31:0] onehot;
  logic        bypass_on;

  regfile_decode #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(1)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr1  (raddr1),
    .raddr2  (raddr2),
    .rdata1  (rdata1),
    .rdata2  (rdata2),
    .wsel    (wsel),
    .written (written),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [63:0] obs);
    logic [63:0] expv;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed=%0h", tag, obs);
    end else begin
      expv = exp_q.pop_front();
      assert (obs === expv) else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
    end
  endtask

  initial begin
`ifdef REGFILE_BYPASS_EN
    bypass_on = 1'b1;
`else
    bypass_on = 1'b0;
`endif
    for (int i = 0; i < NREG; i++) model[i] = 32'h0;

    resetn = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;

    // Reset state: every address reads 0 on both ports.
    for (int a = 0; a < NREG; a++) begin
      @(negedge clk);
      raddr1 = ADDR_W'(a);
      raddr2 = ADDR_W'(NREG - 1 - a);
      #1;
      push(64'h0); check("rst_rdata1", 64'(rdata1));
      push(64'h0); check("rst_rdata2", 64'(rdata2));
    end
    push(64'h0); check("rst_written", 64'(written));
    push(64'h0); check("rst_wr_count", 64'(wr_count));

    // Sweep-write every address; wsel must be one-hot each cycle.
    for (int a = 0; a < NREG; a++) begin
      @(negedge clk);
      we = 1'b1; waddr = ADDR_W'(a); wdata = 32'hA5A5_0000 + 32'(a);
      if (a != 0) model[a] = wdata;
      onehot = 32'h1 << a;
      #1;
      push(64'(onehot)); check("sweep_wsel", 64'(wsel));
    end
    @(negedge clk) we = 1'b0;
    #1;
    push(64'd31); check("sweep_wr_count", 64'(wr_count));
    push(64'hFFFF_FFFE); check("sweep_written", 64'(written));

    for (int a = 0; a < NREG; a++) begin
      @(negedge clk);
      raddr1 = ADDR_W'(a);
      raddr2 = ADDR_W'(NREG - 1 - a);
      #1;
      push(64'(model[a])); check("sweep_rdata1", 64'(rdata1));
      push(64'(model[NREG - 1 - a])); check("sweep_rdata2", 64'(rdata2));
    end

    // Rewrite an already-written register: the count stays saturated at 31.
    @(negedge clk) we = 1'b1; waddr = 5'd31; wdata = 32'h0BAD_F00D; model[31] = 32'h0BAD_F00D;
    @(negedge clk) we = 1'b0; raddr1 = 5'd31;
    #1;
    push(64'd31); check("sat_wr_count", 64'(wr_count));
    push(64'(model[31])); check("sat_rdata1", 64'(rdata1));

    // Same-cycle write and read of register 7 on both ports.
    @(negedge clk);
    we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF; raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
    push(bypass_on ? 64'hDEAD_BEEF : 64'(model[7])); check("same_cyc_rdata1_pre", 64'(rdata1));
    push(bypass_on ? 64'hDEAD_BEEF : 64'(model[7])); check("same_cyc_rdata2_pre", 64'(rdata2));
    model[7] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    push(64'hDEAD_BEEF); check("same_cyc_rdata1_post", 64'(rdata1));
    push(64'hDEAD_BEEF); check("same_cyc_rdata2_post", 64'(rdata2));
    @(negedge clk) we = 1'b0;

    // Mid-sequence reset clears storage, bitmap and count.
    @(negedge clk) resetn = 1'b0;
    @(negedge clk) resetn = 1'b1; raddr1 = 5'd7; raddr2 = 5'd31;
    for (int i = 0; i < NREG; i++) model[i] = 32'h0;
    #1;
    push(64'h0); check("midrst_rdata1", 64'(rdata1));
    push(64'h0); check("midrst_rdata2", 64'(rdata2));
    push(64'h0); check("midrst_written", 64'(written));
    push(64'h0); check("midrst_wr_count", 64'(wr_count));

    // Register 3 written twice: the count increments once.
    @(negedge clk) we = 1'b1; waddr = 5'd3; wdata = 32'h1;
    @(negedge clk) wdata = 32'h2;
    @(negedge clk) we = 1'b0; raddr1 = 5'd3; raddr2 = 5'd3;
    #1;
    push(64'h2); check("rew_rdata1", 64'(rdata1));
    push(64'h2); check("rew_rdata2", 64'(rdata2));
    push(64'h8); check("rew_written", 64'(written));
    push(64'd1); check("rew_wr_count", 64'(wr_count));

    // Write to the hard-wired register 0: wsel reports it, but nothing changes.
    @(negedge clk) we = 1'b1; waddr = 5'd0; wdata = 32'hCAFE_CAFE; raddr1 = 5'd0;
    #1;
    push(64'h1); check("r0_wsel", 64'(wsel));
    push(64'h0); check("r0_rdata1_pre", 64'(rdata1));
    @(negedge clk) we = 1'b0;
    #1;
    push(64'h0); check("r0_rdata1_post", 64'(rdata1));
    push(64'h8); check("r0_written", 64'(written));
    push(64'd1); check("r0_wr_count", 64'(wr_count));

    // Reset coincident with a write: reset wins.
    @(negedge clk) resetn = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'hFFFF_FFFF;
    @(negedge clk) resetn = 1'b1; we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd3;
    #1;
    push(64'h0); check("rstwr_rdata1", 64'(rdata1));
    push(64'h0); check("rstwr_rdata2", 64'(rdata2));
    push(64'h0); check("rstwr_written", 64'(written));
    push(64'h0); check("rstwr_wr_count", 64'(wr_count));

    // The first write after reset release is accepted.
    @(negedge clk) we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678;
    @(negedge clk) we = 1'b0;
    #1;
    push(64'h1234_5678); check("postrst_rdata1", 64'(rdata1));
    push(64'h20); check("postrst_written", 64'(written));
    push(64'd1); check("postrst_wr_count", 64'(wr_count));

    // With we=0, toggling waddr/wdata must neither decode nor write.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      we = 1'b0; waddr = ADDR_W'($urandom_range(0, NREG - 1)); wdata = $urandom;
      #1;
      push(64'h0); check("idle_wsel", 64'(wsel));
    end
    @(negedge clk) waddr = 5'd5; wdata = 32'hFFFF_0000;
    #1;
    push(64'h1234_5678); check("idle_rdata1", 64'(rdata1));
    push(64'h20); check("idle_written", 64'(written));
    push(64'd1); check("idle_wr_count", 64'(wr_count));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
